// File: rtl/calib_pkg.sv
// Shared constants and types for the calibration list loader: default widths,
// ASCII character codes, loader states and error codes.
package calib_pkg;

    localparam int CALIB_DATA_W = 20;
    localparam int CALIB_DEPTH  = 1024;
    localparam int CALIB_ADDR_W = 10;

    localparam logic [7:0] PLUS  = 8'h2B;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SIGN  = 3'd1,
        ST_DIGIT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_CHAR  = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_LIST_FULL = 2'd3
    } err_t;

endpackage

// File: rtl/calib_line_accumulator.sv
// Per-line sign/magnitude accumulator. Results are presented combinationally so
// the digit arriving this cycle is already folded into result/has_digit.
module calib_line_accumulator
    import calib_pkg::*;
#(
    parameter int DATA_W = CALIB_DATA_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    input  logic                     neg_in,
    input  logic                     digit_en,
    input  logic [3:0]               digit,
    output logic                     overflow,
    output logic                     has_digit,
    output logic signed [DATA_W-1:0] result
);

    localparam int MAG_W = DATA_W + 4;

    logic             neg;
    logic             ndig_nz;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] mag_next;
    logic [MAG_W-1:0] limit;
    logic [MAG_W-1:0] mag_sel;
    logic [MAG_W-1:0] mag_signed;

    // Negative lines may reach one step further: -2^(DATA_W-1) is representable.
    always_comb begin
        mag_next   = mag * MAG_W'(10) + MAG_W'(digit);
        limit      = neg ? (MAG_W'(1) << (DATA_W - 1))
                         : ((MAG_W'(1) << (DATA_W - 1)) - MAG_W'(1));
        overflow   = digit_en && (mag_next > limit);
        has_digit  = ndig_nz || digit_en;
        mag_sel    = digit_en ? mag_next : mag;
        mag_signed = neg ? (~mag_sel + MAG_W'(1)) : mag_sel;
        result     = $signed(mag_signed[DATA_W-1:0]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            neg     <= 1'b0;
            ndig_nz <= 1'b0;
            mag     <= '0;
        end else if (clear) begin
            neg     <= neg_in;
            ndig_nz <= 1'b0;
            mag     <= '0;
        end else if (digit_en && !overflow) begin
            ndig_nz <= 1'b1;
            mag     <= mag_next;
        end
    end

endmodule

// File: rtl/calibration_list_loader.sv
// Parses an ASCII stream of signed decimal lines into a signed list plus length
// for frequency_calibrator; done pulses once per clean load.
module calibration_list_loader
    import calib_pkg::*;
#(
    parameter int DATA_W = CALIB_DATA_W,
    parameter int DEPTH  = CALIB_DEPTH,
    parameter int ADDR_W = CALIB_ADDR_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic [7:0]               byte_data,
    input  logic                     byte_last,
    output logic signed [DATA_W-1:0] calibration_list [DEPTH],
    output logic [ADDR_W-1:0]        calibration_list_length,
    output logic                     ready,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               error_code,
    output logic [2:0]               state_dbg
);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
    // byte_ready is high only while parsing (SIGN/DIGIT); a byte offered in a
    // start cycle transfers but is discarded by the restart.

    state_t              state;
    state_t              state_nxt;
    err_t                err_q;
    err_t                err_nxt;
    logic [ADDR_W-1:0]   length;
    logic                loading;
    logic                accept;
    logic                is_plus;
    logic                is_minus;
    logic                is_lf;
    logic                is_cr;
    logic                is_digit;
    logic                acc_clear;
    logic                acc_neg;
    logic                digit_en;
    logic                commit;
    logic                commit_ok;
    logic                acc_overflow;
    logic                acc_has_digit;
    logic signed [DATA_W-1:0] acc_result;

    assign loading    = (state == ST_SIGN) || (state == ST_DIGIT);
    assign byte_ready = loading;
    assign accept     = byte_valid && byte_ready && !start;

    assign is_plus  = (byte_data == PLUS);
    assign is_minus = (byte_data == MINUS);
    assign is_lf    = (byte_data == LF);
    assign is_cr    = (byte_data == CR);
    assign is_digit = (byte_data >= ZERO) && (byte_data <= NINE);

    calib_line_accumulator #(.DATA_W(DATA_W)) u_acc (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (acc_clear),
        .neg_in    (acc_neg),
        .digit_en  (digit_en),
        .digit     (byte_data[3:0]),
        .overflow  (acc_overflow),
        .has_digit (acc_has_digit),
        .result    (acc_result)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        acc_clear = 1'b0;
        acc_neg   = 1'b0;
        digit_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_DONE: state_nxt = ST_IDLE;
            ST_SIGN: begin
                if (accept) begin
                    if (is_plus || is_minus) begin
                        acc_clear = 1'b1;
                        acc_neg   = is_minus;
                        if (byte_last) begin
                            state_nxt = ST_ERROR;
                            err_nxt   = ERR_BAD_CHAR;
                        end else begin
                            state_nxt = ST_DIGIT;
                        end
                    end else if (is_lf || is_cr) begin
                        if (byte_last) state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ERROR;
                        err_nxt   = ERR_BAD_CHAR;
                    end
                end
            end
            ST_DIGIT: begin
                if (accept) begin
                    if (is_digit) begin
                        digit_en = 1'b1;
                        if (acc_overflow) begin
                            state_nxt = ST_ERROR;
                            err_nxt   = ERR_OVERFLOW;
                        end else if (byte_last) begin
                            commit    = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end else if (is_cr && !byte_last) begin
                        state_nxt = ST_DIGIT;
                    end else if ((is_lf || is_cr) && acc_has_digit) begin
                        commit    = 1'b1;
                        state_nxt = byte_last ? ST_DONE : ST_SIGN;
                    end else begin
                        state_nxt = ST_ERROR;
                        err_nxt   = ERR_BAD_CHAR;
                    end
                end
            end
            default: state_nxt = state;
        endcase

        // The last slot is never written so the length always fits ADDR_W bits.
        commit_ok = commit && (length != ADDR_W'(DEPTH - 1));
        if (commit && !commit_ok) begin
            state_nxt = ST_ERROR;
            err_nxt   = ERR_LIST_FULL;
        end

        if (start) begin
            state_nxt = ST_SIGN;
            err_nxt   = ERR_NONE;
            acc_clear = 1'b1;
            acc_neg   = 1'b0;
            digit_en  = 1'b0;
            commit_ok = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            err_q  <= ERR_NONE;
            length <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (start) begin
                length <= '0;
            end else if (commit_ok) begin
                length <= length + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (commit_ok && !RST) begin
            calibration_list[length] <= acc_result;
        end
    end

    assign calibration_list_length = length;
    assign ready      = !loading;
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);
    assign error_code = err_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_calibration_list_loader.sv
// Directed bench for calibration_list_loader: a stream-level parsing model
// predicts list/length/error for each stream; a negedge monitor checks every cycle.
module tb_calibration_list_loader;
    import calib_pkg::*;

    localparam int DW    = 20;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 start = 1'b0;
    logic                 byte_valid = 1'b0;
    logic                 byte_ready;
    logic [7:0]           byte_data = 8'h00;
    logic                 byte_last = 1'b0;
    logic signed [DW-1:0] cal_list [DEPTH];
    logic [AW-1:0]        cal_len;
    logic                 ready;
    logic                 done;
    logic                 error;
    logic [1:0]           error_code;
    logic [2:0]           state_dbg;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic       done_prev = 1'b0;
    bit         mon_en = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    stim_q[$];

    calibration_list_loader dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .start                   (start),
        .byte_valid              (byte_valid),
        .byte_ready              (byte_ready),
        .byte_data               (byte_data),
        .byte_last               (byte_last),
        .calibration_list        (cal_list),
        .calibration_list_length (cal_len),
        .ready                   (ready),
        .done                    (done),
        .error                   (error),
        .error_code              (error_code),
        .state_dbg               (state_dbg)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every cycle: ready and byte_ready are exclusive, done is a lone pulse never with error.
    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            chk("ready_vs_byte_ready", {31'd0, ready}, {31'd0, ~byte_ready});
            if (done) begin
                done_cnt++;
                chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
                chk("done_without_error", {31'd0, error}, 32'd0);
            end
            done_prev = done;
        end
    end

    // Stream-level model: returns the error code the stream ends in, fills exp_q.
    function automatic int model_run();
        bit     in_num = 1'b0;
        bit     neg = 1'b0;
        longint mag = 0;
        int     nd = 0;
        int     n = stim_q.size();
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = stim_q[i];
            if (!in_num) begin
                if (b == PLUS || b == MINUS) begin
                    in_num = 1'b1;
                    neg = (b == MINUS);
                    mag = 0;
                    nd = 0;
                end else if (b != LF && b != CR) begin
                    return 1;
                end
            end else begin
                if (b >= ZERO && b <= NINE) begin
                    mag = mag * 10 + longint'(b - ZERO);
                    nd++;
                    if (mag > (neg ? (64'sd1 <<< (DW - 1)) : ((64'sd1 <<< (DW - 1)) - 1))) return 2;
                end else if (b == LF) begin
                    if (nd == 0) return 1;
                    if (exp_q.size() == DEPTH - 1) return 3;
                    exp_q.push_back(DW'(neg ? -mag : mag));
                    in_num = 1'b0;
                end else if (b != CR) begin
                    return 1;
                end
            end
            if (i == n - 1 && in_num) begin
                if (nd == 0) return 1;
                if (exp_q.size() == DEPTH - 1) return 3;
                exp_q.push_back(DW'(neg ? -mag : mag));
            end
        end
        return 0;
    endfunction

    task automatic load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic do_start();
        done_cnt = 0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Drives stim_q; stops quietly if the loader stops accepting (error state).
    task automatic send(input bit gaps, input bit with_last);
        int w;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                byte_last = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
            byte_valid = 1'b1;
            byte_data = stim_q[i];
            byte_last = with_last && (i == stim_q.size() - 1);
            w = 0;
            while (!byte_ready && w < 8) begin
                @(negedge CLK);
                w++;
            end
            if (!byte_ready) begin
                byte_valid = 1'b0;
                byte_last = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    task automatic run_stim(input string name, input bit gaps);
        int code;
        int w;
        code = model_run();
        do_start();
        send(gaps, 1'b1);
        w = 0;
        while (!ready && w < 40) begin
            @(negedge CLK);
            w++;
        end
        chk({name, "_ready_after"}, {31'd0, ready}, 32'd1);
        repeat (2) @(negedge CLK);
        chk({name, "_length"}, 32'(cal_len), 32'(exp_q.size()));
        chk({name, "_error"}, {31'd0, error}, {31'd0, code != 0});
        chk({name, "_code"}, {30'd0, error_code}, 32'(code));
        chk({name, "_done_count"}, 32'(done_cnt), (code == 0) ? 32'd1 : 32'd0);
        foreach (exp_q[i]) chk({name, "_entry"}, {12'd0, cal_list[i]}, {12'd0, exp_q[i]});
    endtask

    task automatic run_str(input string name, input string s, input bit gaps);
        load_str(s);
        run_stim(name, gaps);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_code", {30'd0, error_code}, 32'd0);
        chk("rst_length", 32'(cal_len), 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        mon_en = 1'b1;

        run_str("t1", "+1\n-2\n+3\n+1\n", 1'b1);
        chk("t1_len_lit", 32'(cal_len), 32'd4);
        chk("t1_e1_lit", {12'd0, cal_list[1]}, 32'h000FFFFE);
        chk("t1_e2_lit", {12'd0, cal_list[2]}, 32'h00000003);

        run_str("t2", "+7", 1'b0);
        chk("t2_e0_lit", {12'd0, cal_list[0]}, 32'h00000007);

        run_str("t3a", "+524287\n-524288\n", 1'b1);
        chk("t3a_e0_lit", {12'd0, cal_list[0]}, 32'h0007FFFF);
        chk("t3a_e1_lit", {12'd0, cal_list[1]}, 32'h00080000);
        run_str("t3b", "+524288\n", 1'b0);
        chk("t3b_code_lit", {30'd0, error_code}, 32'd2);
        run_str("t3c", "-524289\n", 1'b0);
        run_str("t3d", "-0012\r\n", 1'b1);

        run_str("t4a", "+5\r\n\n+x\n", 1'b1);
        chk("t4a_len_lit", 32'(cal_len), 32'd1);
        run_str("t4b", "+\n", 1'b0);
        run_str("t4c", "\n", 1'b0);
        run_str("t4d", "+3\n-", 1'b0);
        run_str("t4e", "+8\r", 1'b0);

        // Restart mid-stream: only the lines after the second start survive.
        load_str("+9\n+9");
        do_start();
        send(1'b1, 1'b0);
        run_str("t5", "-3\n", 1'b1);
        chk("t5_e0_lit", {12'd0, cal_list[0]}, 32'h000FFFFD);

        load_str("+4\n+5");
        do_start();
        send(1'b1, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_length", 32'(cal_len), 32'd0);
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_byte_ready", {31'd0, byte_ready}, 32'd0);

        RST = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        chk("rst_start_ready", {31'd0, ready}, 32'd1);
        chk("rst_start_byte_ready", {31'd0, byte_ready}, 32'd0);

        stim_q.delete();
        for (int i = 0; i < DEPTH - 1; i++) begin
            stim_q.push_back(PLUS);
            stim_q.push_back(8'h31);
            stim_q.push_back(LF);
        end
        run_stim("t6a", 1'b0);
        chk("t6a_len_lit", 32'(cal_len), 32'd1023);
        stim_q.push_back(PLUS);
        stim_q.push_back(8'h31);
        stim_q.push_back(LF);
        run_stim("t6b", 1'b0);
        chk("t6b_len_lit", 32'(cal_len), 32'd1023);
        chk("t6b_code_lit", {30'd0, error_code}, 32'd3);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
